// File: rtl/hazard_fwd_unit_pkg.sv
// rtl/hazard_fwd_unit_pkg.sv - shared widths, MIPS opcodes and forward-select codes
package hazard_fwd_unit_pkg;

  localparam int AWIDTH       = 5;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] ADDI  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] ADDIU = 6'h09;
  localparam logic [OPCODE_WIDTH-1:0] SLTI  = 6'h0a;
  localparam logic [OPCODE_WIDTH-1:0] SLTIU = 6'h0b;
  localparam logic [OPCODE_WIDTH-1:0] ANDI  = 6'h0c;
  localparam logic [OPCODE_WIDTH-1:0] ORI   = 6'h0d;
  localparam logic [OPCODE_WIDTH-1:0] LOAD  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] STORE = 6'h2b;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID-side hazard/forwarding bundle between core and hazard unit
interface hazard_fwd_unit_if
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RAW = AWIDTH,
  parameter int OPW = OPCODE_WIDTH
);

  logic           id_valid;
  logic [OPW-1:0] id_opcode;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic           id_uses_rs;
  logic           id_uses_rt;
  logic [RAW-1:0] id_wr_addr;
  logic           flush;
  logic           stall;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;
  logic [RAW-1:0] wb_wr_addr;
  logic           wb_wr_en;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_addr, flush,
    input  stall, fwd_a, fwd_b, wb_wr_addr, wb_wr_en
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_addr, flush,
    output stall, fwd_a, fwd_b, wb_wr_addr, wb_wr_en
  );

endinterface

// File: rtl/hazard_fwd_unit_dest_track_stage.sv
// rtl/hazard_fwd_unit_dest_track_stage.sv - one destination-tracking pipeline stage
module dest_track_stage
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RAW = AWIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  input  logic [RAW-1:0] up_wr_addr,
  input  logic           up_wr_en,
  input  logic           up_is_load,
  output logic           valid,
  output logic [RAW-1:0] wr_addr,
  output logic           wr_en,
  output logic           is_load
);

  // An invalid upstream slot becomes a fully zeroed bubble so nothing downstream can match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      wr_addr <= '0;
      wr_en   <= 1'b0;
      is_load <= 1'b0;
    end else if (up_valid) begin
      valid   <= 1'b1;
      wr_addr <= up_wr_addr;
      wr_en   <= up_wr_en;
      is_load <= up_is_load;
    end else begin
      valid   <= 1'b0;
      wr_addr <= '0;
      wr_en   <= 1'b0;
      is_load <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - destination tracking, EX operand forwarding and load-use stall
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RAW = AWIDTH,
  parameter int OPW = OPCODE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave bus
);

  logic           id_writer;
  logic           id_wr_en;
  logic           id_is_load;
  logic           id_adv;
  logic           stall_c;

  logic           ex_valid, mem_valid, wb_valid;
  logic [RAW-1:0] ex_wr_addr, mem_wr_addr, wb_wr_addr;
  logic           ex_wr_en, mem_wr_en, wb_wr_en;
  logic           ex_is_load, mem_is_load, wb_is_load;

  logic [RAW-1:0] ex_rs;
  logic [RAW-1:0] ex_rt;
  logic           ex_uses_rs;
  logic           ex_uses_rt;

  always_comb begin
    id_writer = 1'b0;
    case (bus.id_opcode)
      LOAD, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, RTYPE: id_writer = 1'b1;
      default:                                          id_writer = 1'b0;
    endcase
  end

  // A zero destination never writes, which keeps $0 out of every forward and stall match.
  assign id_wr_en   = id_writer && (bus.id_wr_addr != '0);
  assign id_is_load = (bus.id_opcode == LOAD);
  assign id_adv     = bus.id_valid && !bus.flush && !stall_c;

  assign stall_c = bus.id_valid && !bus.flush &&
                   ex_valid && ex_wr_en && ex_is_load &&
                   ((bus.id_uses_rs && (bus.id_rs == ex_wr_addr)) ||
                    (bus.id_uses_rt && (bus.id_rt == ex_wr_addr)));

  dest_track_stage #(.RAW(RAW)) u_ex (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (id_adv),
    .up_wr_addr (bus.id_wr_addr),
    .up_wr_en   (id_wr_en),
    .up_is_load (id_is_load),
    .valid      (ex_valid),
    .wr_addr    (ex_wr_addr),
    .wr_en      (ex_wr_en),
    .is_load    (ex_is_load)
  );

  dest_track_stage #(.RAW(RAW)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (ex_valid),
    .up_wr_addr (ex_wr_addr),
    .up_wr_en   (ex_wr_en),
    .up_is_load (ex_is_load),
    .valid      (mem_valid),
    .wr_addr    (mem_wr_addr),
    .wr_en      (mem_wr_en),
    .is_load    (mem_is_load)
  );

  dest_track_stage #(.RAW(RAW)) u_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (mem_valid),
    .up_wr_addr (mem_wr_addr),
    .up_wr_en   (mem_wr_en),
    .up_is_load (mem_is_load),
    .valid      (wb_valid),
    .wr_addr    (wb_wr_addr),
    .wr_en      (wb_wr_en),
    .is_load    (wb_is_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_uses_rs <= 1'b0;
      ex_uses_rt <= 1'b0;
    end else if (id_adv) begin
      ex_rs      <= bus.id_rs;
      ex_rt      <= bus.id_rt;
      ex_uses_rs <= bus.id_uses_rs;
      ex_uses_rt <= bus.id_uses_rt;
    end else begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_uses_rs <= 1'b0;
      ex_uses_rt <= 1'b0;
    end
  end

  function automatic logic [1:0] fwd_select(
    input logic           uses,
    input logic [RAW-1:0] src
  );
    if (uses && mem_valid && mem_wr_en && (mem_wr_addr == src))
      return FWD_MEM;
    else if (uses && wb_valid && wb_wr_en && (wb_wr_addr == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign bus.stall      = stall_c;
  assign bus.fwd_a      = fwd_select(ex_uses_rs, ex_rs);
  assign bus.fwd_b      = fwd_select(ex_uses_rt, ex_rt);
  assign bus.wb_wr_addr = wb_wr_addr;
  assign bus.wb_wr_en   = wb_wr_en;

`ifndef SYNTHESIS
  // A load sitting in MEM with its consumer in EX means the stall bubble was lost.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(ex_valid && mem_valid && mem_wr_en && mem_is_load &&
                ((ex_uses_rs && (mem_wr_addr == ex_rs)) ||
                 (ex_uses_rt && (mem_wr_addr == ex_rt)))));
      assert (ex_valid  || (!ex_wr_en  && !ex_is_load  && (ex_wr_addr  == '0)));
      assert (mem_valid || (!mem_wr_en && !mem_is_load && (mem_wr_addr == '0)));
      assert (wb_valid  || (!wb_wr_en  && !wb_is_load  && (wb_wr_addr  == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit with in-flight instruction model
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.RAW(5), .OPW(6)) bus ();

  hazard_fwd_unit #(.RAW(5), .OPW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       valid;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic       urs;
    logic       urt;
  } instr_t;

  typedef struct {
    logic       writes;
    logic       load;
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
  } flight_t;

  typedef struct {
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       wen;
    logic [4:0] waddr;
  } exp_t;

  exp_t    sb[$];
  flight_t inflight[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flight_t empty_slot();
    flight_t f;
    f.writes = 1'b0; f.load = 1'b0; f.wa = '0;
    f.rs = '0; f.rt = '0; f.urs = 1'b0; f.urt = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    inflight.delete();
    repeat (3) inflight.push_back(empty_slot());
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd);
    instr_t i;
    i.valid = 1'b1; i.op = op; i.rs = rs; i.rt = rt;
    if (op == RTYPE) begin
      i.urs = 1'b1; i.urt = 1'b1; i.wa = rd;
    end else if (op inside {LOAD, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI}) begin
      i.urs = 1'b1; i.urt = 1'b0; i.wa = rt;
    end else begin
      i.urs = 1'b1; i.urt = 1'b1; i.wa = '0;
    end
    return i;
  endfunction

  function automatic instr_t idle_instr();
    instr_t i;
    i = mk(RTYPE, 5'd0, 5'd0, 5'd0);
    i.valid = 1'b0;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t     i;
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = RTYPE;
      2, 3:    op = LOAD;
      4:       op = ADDI;
      5:       op = ADDIU;
      6:       op = SLTI;
      7:       op = ANDI;
      8:       op = STORE;
      default: op = BEQ;
    endcase
    i = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    i.valid = ($urandom_range(0, 9) != 0);
    return i;
  endfunction

  function automatic logic [1:0] producer_sel(input logic uses, input logic [4:0] src,
                                              input flight_t older1, input flight_t older2);
    if (uses && older1.writes && older1.wa == src) return 2'b10;
    if (uses && older2.writes && older2.wa == src) return 2'b01;
    return 2'b00;
  endfunction

  // inflight[0] is the instruction now in EX, [1] one stage older, [2] the oldest.
  task automatic model_cycle(input instr_t i, input logic fl, output exp_t e);
    flight_t ex, mem, wb, nxt;
    logic    writes;
    ex  = inflight[0];
    mem = inflight[1];
    wb  = inflight[2];
    writes = (i.op inside {LOAD, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, RTYPE}) && (i.wa != 0);
    e.stall = i.valid && !fl && ex.load && ex.writes &&
              ((i.urs && i.rs == ex.wa) || (i.urt && i.rt == ex.wa));
    e.fa    = producer_sel(ex.urs, ex.rs, mem, wb);
    e.fb    = producer_sel(ex.urt, ex.rt, mem, wb);
    e.wen   = wb.writes;
    e.waddr = wb.wa;
    nxt = empty_slot();
    if (i.valid && !fl && !e.stall) begin
      nxt.writes = writes; nxt.load = (i.op == LOAD); nxt.wa = i.wa;
      nxt.rs = i.rs; nxt.rt = i.rt; nxt.urs = i.urs; nxt.urt = i.urt;
    end
    inflight.push_front(nxt);
    void'(inflight.pop_back());
  endtask

  task automatic drive(input instr_t i, input logic fl);
    bus.id_valid   = i.valid;
    bus.id_opcode  = i.op;
    bus.id_rs      = i.rs;
    bus.id_rt      = i.rt;
    bus.id_uses_rs = i.urs;
    bus.id_uses_rt = i.urt;
    bus.id_wr_addr = i.wa;
    bus.flush      = fl;
  endtask

  // Starts and ends at posedge+1; a stalled instruction is re-presented until it advances.
  task automatic issue(input instr_t i, input logic fl);
    exp_t e;
    int   tries = 0;
    do begin
      drive(i, fl);
      model_cycle(i, fl, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      tries++;
    end while (e.stall && tries < 4);
    if (e.stall) chk("stall_bound", tries, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(idle_instr(), 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, int'(bus.stall), 0);
    chk({tag, "_fwd_a"}, int'(bus.fwd_a), 0);
    chk({tag, "_fwd_b"}, int'(bus.fwd_b), 0);
    chk({tag, "_wb_en"}, int'(bus.wb_wr_en), 0);
    chk({tag, "_wb_addr"}, int'(bus.wb_wr_addr), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stall", int'(bus.stall), int'(e.stall));
        chk("fwd_a", int'(bus.fwd_a), int'(e.fa));
        chk("fwd_b", int'(bus.fwd_b), int'(e.fb));
        chk("wb_wr_en", int'(bus.wb_wr_en), int'(e.wen));
        chk("wb_wr_addr", int'(bus.wb_wr_addr), int'(e.waddr));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    drive(idle_instr(), 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    issue(mk(RTYPE, 5'd1, 5'd2, 5'd3), 1'b0);
    issue(mk(RTYPE, 5'd3, 5'd4, 5'd8), 1'b0);
    idle(4);

    issue(mk(ADDI, 5'd1, 5'd7, 5'd0), 1'b0);
    idle(1);
    issue(mk(RTYPE, 5'd1, 5'd7, 5'd9), 1'b0);
    idle(4);

    issue(mk(RTYPE, 5'd1, 5'd1, 5'd2), 1'b0);
    issue(mk(ADDI, 5'd3, 5'd2, 5'd0), 1'b0);
    issue(mk(RTYPE, 5'd2, 5'd2, 5'd10), 1'b0);
    idle(4);

    issue(mk(LOAD, 5'd1, 5'd5, 5'd0), 1'b0);
    issue(mk(RTYPE, 5'd6, 5'd5, 5'd11), 1'b0);
    idle(4);
    issue(mk(LOAD, 5'd1, 5'd5, 5'd0), 1'b0);
    issue(mk(RTYPE, 5'd6, 5'd5, 5'd11), 1'b1);
    idle(4);

    issue(mk(RTYPE, 5'd1, 5'd2, 5'd0), 1'b0);
    issue(mk(RTYPE, 5'd0, 5'd0, 5'd12), 1'b0);
    issue(mk(STORE, 5'd1, 5'd13, 5'd0), 1'b0);
    issue(mk(RTYPE, 5'd13, 5'd13, 5'd14), 1'b0);
    idle(4);

    issue(mk(RTYPE, 5'd1, 5'd2, 5'd3), 1'b0);
    issue(mk(RTYPE, 5'd1, 5'd2, 5'd4), 1'b0);
    issue(mk(RTYPE, 5'd1, 5'd2, 5'd5), 1'b0);
    drive(idle_instr(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(mk(RTYPE, 5'd3, 5'd1, 5'd6), 1'b0);
    idle(4);

    for (int n = 0; n < 400; n++)
      issue(rnd_instr(), 1'($urandom_range(0, 9) == 0));
    idle(4);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Consumes the write-register address selected in ID by the destination mux (rt for I-type, rd for R-type, 0 otherwise) and carries it, with decoded write/load flags, through internal EX, MEM and WB tracking registers.
- From that tracked state it drives the EX-stage ALU-operand forwarding selects, the load-use stall, and the register-file write port address/enable.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.

Parameters:
- RAW, default `AWIDTH (5): register address width.
- OPW, default `OPCODE_WIDTH (6): opcode width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  OPW  ID instruction opcode.
- id_rs  in  RAW  ID source register rs.
- id_rt  in  RAW  ID source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_wr_addr  in  RAW  destination address from the ID destination mux.
- flush  in  1  branch/jump taken; discard the ID instruction.
- stall  out  1  load-use hazard; hold PC and IF/ID, bubble into EX.
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding.
- wb_wr_addr  out  RAW  register-file write address.
- wb_wr_en  out  1  register-file write enable.

Behaviour:
- Decode (combinational, ID):
  - wr_en = opcode in {LOAD, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, RTYPE} AND id_wr_addr != 0.
  - is_load = (opcode == LOAD).
- Tracking registers: per stage EX/MEM/WB: valid, wr_addr, wr_en, is_load. EX additionally holds ex_rs, ex_rt, ex_uses_rs, ex_uses_rt.
- Every rising clk:
  - MEM <= EX; WB <= MEM.
  - EX <= ID fields with valid = id_valid & ~flush & ~stall.
  - When valid = 0 the stage is a bubble: wr_en = 0, is_load = 0, addrs = 0.
- Reset (async, rst_n = 0): all valid/wr_en/is_load = 0 and all addrs = 0 immediately. Outputs read stall = 0, fwd_a = fwd_b = 00, wb_wr_en = 0, wb_wr_addr = 0. Asserting reset mid-operation discards all in-flight state with no residual forwards. Deassertion is synchronised externally.
- stall (combinational) = ex_valid & ex_wr_en & ex_is_load & ((id_uses_rs & id_rs == ex_wr_addr) | (id_uses_rt & id_rt == ex_wr_addr)) & id_valid & ~flush.
  - Asserts for exactly one cycle per load-use pair; the bubble removes the condition next cycle.
  - flush has priority and forces stall = 0.
- fwd_a (combinational, EX):
  - 10 if ex_uses_rs & mem_valid & mem_wr_en & mem_wr_addr == ex_rs.
  - else 01 if ex_uses_rs & wb_valid & wb_wr_en & wb_wr_addr == ex_rs.
  - else 00.
  - MEM wins over WB (youngest producer).
- fwd_b: same as fwd_a using ex_rt / ex_uses_rt.
- A MEM-stage match on a load is unreachable because stall guarantees a bubble. The implementation carries a simulation-only assertion that fires if it occurs.
- Register $0 never produces a forward, stall, or write, because wr_en is 0 whenever the address is 0.
- wb_wr_addr and wb_wr_en are registered outputs straight from the WB tracking registers. The register file is write-first, so no ID-stage WB forwarding is needed here.
- Latency: forwarding and stall are zero-cycle combinational from the tracking registers; the destination reaches WB 3 clocks after leaving ID.

Decomposition:
- Shared header (existing): `AWIDTH, `OPCODE_WIDTH, opcode constants LOAD/ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/RTYPE, and new FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One natural sub-module: dest_track_stage, a single tracking-register stage (valid, addr, wr_en, is_load, with bubble insert) instantiated three times.
- The write-enable decode stays inline.

Test Plan:
- Reset mid-stream: issue three R-types writing $3/$4/$5, pull rst_n low between edges -> all outputs 0 immediately; after release, EX consumer of $3 sees fwd_a = 00.
- Back-to-back RAW: ADD $3 then SUB rs = $3 -> next cycle fwd_a = 10, fwd_b = 00, stall = 0.
- Distance 2: ADDI $7 (rt = 7), NOP, OR rt = $7 -> fwd_b = 01 when OR is in EX.
- Double producer: ADD $2, ADDI $2, AND rs = rt = $2 -> fwd_a = fwd_b = 10 (MEM priority).
- Load-use: LW $5, then ADD rt = $5 in ID -> stall = 1 for exactly one cycle and an EX bubble; the following cycle fwd_b = 01. Repeat with flush = 1 during the hazard -> stall = 0 and EX bubble.
- $0 destination / non-writer: ADD rd = $0 then a consumer of $0, and an SW then a consumer of its rt -> fwd = 00, stall = 0, wb_wr_en = 0 three cycles later.
